mop_rename_queue: RTL and testbench

Receive-side micro-op queue between the decode stage and the rename stage. Each cycle it accepts up to DECODE_WIDTH decoded micro-ops with sparse lane valids and compacts them in program order into a circular buffer. It presents up to RENAME_WIDTH of the oldest entries to rename and enforces the serialized-op rule on the consumer side: a serialized op always leaves alone. It decouples decode from rename back-pressure, so decode no longer stalls on a single-cycle rename stall.

---
 rtl/mop_rename_queue_pkg.sv | 21 ++
 rtl/mop_rename_queue_compactor.sv | 24 ++
 rtl/mop_rename_queue.sv | 151 +++++++++++++++
 tb/tb_mop_rename_queue.sv | 215 +++++++++++++++++++++
 4 files changed

// File: rtl/mop_rename_queue_pkg.sv
// Shared micro-op types for the decode-to-rename queue.
// Types and constants only; no logic, no latency.
// No flow control here; users apply their own handshake.
package mop_rename_queue_pkg;

  localparam int MOP_QUEUE_DEPTH  = 8;
  localparam int MOP_DECODE_WIDTH = 2;
  localparam int MOP_RENAME_WIDTH = 2;

  typedef logic [$clog2(MOP_QUEUE_DEPTH)-1:0]   MopQueueIndexPath;
  typedef logic [$clog2(MOP_QUEUE_DEPTH+1)-1:0] MopQueueCountPath;

  typedef struct packed {
    logic [15:0] opInfo;
    logic [31:0] pc;
    logic [1:0]  bPred;
    logic [7:0]  opId;
    logic        serialized;
  } MopEntry;

endpackage

// File: rtl/mop_rename_queue_compactor.sv
// Lane compactor: maps sparse lane valids to dense write offsets plus a total.
// Purely combinational, zero latency.
// No backpressure; the caller decides whether the group is taken.
module mop_rename_queue_compactor #(
  parameter int DECODE_WIDTH = 2,
  parameter int OFS_W        = $clog2(DECODE_WIDTH + 1)
) (
  input  logic [DECODE_WIDTH-1:0]            valid_i,
  output logic [DECODE_WIDTH-1:0][OFS_W-1:0] offset_o,
  output logic [OFS_W-1:0]                   num_o
);

  // Each lane's offset is the number of valid lanes below it (exclusive prefix count).
  always_comb begin
    logic [OFS_W-1:0] acc;
    acc = '0;
    for (int i = 0; i < DECODE_WIDTH; i++) begin
      offset_o[i] = acc;
      acc = acc + OFS_W'(valid_i[i]);
    end
    num_o = acc;
  end

endmodule

// File: rtl/mop_rename_queue.sv
// Decode-to-rename micro-op queue: compacts sparse decode groups into a ring, serves oldest to rename.
// Latency 1 cycle enqueue-to-output; 0 when empty if RSD_MOP_QUEUE_BYPASS_EN is defined.
// inReady depends only on registered occupancy; rename accepts all valid lanes or none.
module mop_rename_queue
  import mop_rename_queue_pkg::*;
#(
  parameter int DECODE_WIDTH = MOP_DECODE_WIDTH,
  parameter int RENAME_WIDTH = MOP_RENAME_WIDTH,
  parameter int QUEUE_DEPTH  = MOP_QUEUE_DEPTH
) (
  input  logic                               clk,
  input  logic                               rst,
  input  logic                               flush,
  input  logic [DECODE_WIDTH-1:0]            inValid,
  input  MopEntry [DECODE_WIDTH-1:0]         inOp,
  output logic                               inReady,
  output logic [RENAME_WIDTH-1:0]            outValid,
  output MopEntry [RENAME_WIDTH-1:0]         outOp,
  input  logic                               outAccept,
  output logic [$clog2(QUEUE_DEPTH+1)-1:0]   count
);

  localparam int PW   = $clog2(QUEUE_DEPTH);
  localparam int CW   = $clog2(QUEUE_DEPTH + 1);
  localparam int EW   = $clog2(DECODE_WIDTH + 1);
  localparam int RW_W = $clog2(RENAME_WIDTH + 1);

  MopEntry                        mem_q [QUEUE_DEPTH];
  logic [PW-1:0]                  head_q, head_d;
  logic [PW-1:0]                  tail_q, tail_d;
  logic [CW-1:0]                  count_q, count_d;

  logic [DECODE_WIDTH-1:0][EW-1:0] lane_ofs;
  logic [EW-1:0]                  enq_num;
  MopEntry                        comp [DECODE_WIDTH];
  MopEntry                        cand [RENAME_WIDTH];
  logic [CW-1:0]                  cand_num;
  logic                           byp_sel;
  logic                           enq_fire;
  logic                           deq_fire;
  logic [RW_W-1:0]                deq_num;
  logic [RW_W-1:0]                q_deq;
  logic [EW-1:0]                  byp_skip;
  logic [EW-1:0]                  enq_wr;

  mop_rename_queue_compactor #(
    .DECODE_WIDTH (DECODE_WIDTH),
    .OFS_W        (EW)
  ) u_compactor (
    .valid_i  (inValid),
    .offset_o (lane_ofs),
    .num_o    (enq_num)
  );

  // Room for a whole group is judged from registered occupancy only.
  assign inReady  = (count_q <= CW'(QUEUE_DEPTH - DECODE_WIDTH));
  assign enq_fire = inReady && (|inValid) && !flush;
  assign count    = count_q;

  // Squeeze the holes out of the decode group: compacted slot c holds the c-th valid lane.
  always_comb begin
    for (int c = 0; c < DECODE_WIDTH; c++) begin
      comp[c] = '0;
      for (int i = 0; i < DECODE_WIDTH; i++) begin
        if (inValid[i] && (lane_ofs[i] == EW'(c))) comp[c] = inOp[i];
      end
    end
  end

  // Candidate window: oldest queued entries, or the compacted input group when bypassing an empty queue.
  always_comb begin
    byp_sel  = 1'b0;
    cand_num = count_q;
    for (int l = 0; l < RENAME_WIDTH; l++) cand[l] = mem_q[head_q + PW'(l)];
`ifdef RSD_MOP_QUEUE_BYPASS_EN
    if ((count_q == '0) && !flush) begin
      byp_sel  = 1'b1;
      cand_num = CW'(enq_num);
      for (int l = 0; l < RENAME_WIDTH; l++) cand[l] = '0;
      for (int l = 0; l < RENAME_WIDTH && l < DECODE_WIDTH; l++) cand[l] = comp[l];
    end
`endif
  end

  // A serialized op only ever occupies lane 0 on its own; it closes the window before it otherwise.
  always_comb begin
    logic stop;
    stop     = 1'b0;
    outValid = '0;
    for (int l = 0; l < RENAME_WIDTH; l++) begin
      outOp[l] = cand[l];
      if ((CW'(l) < cand_num) && !stop) begin
        if ((l == 0) || !cand[l].serialized) outValid[l] = 1'b1;
        if (cand[l].serialized) stop = 1'b1;
      end
    end
  end

  // Number of lanes rename takes this cycle when it accepts.
  always_comb begin
    deq_num = '0;
    for (int l = 0; l < RENAME_WIDTH; l++) deq_num = deq_num + RW_W'(outValid[l]);
  end

  assign deq_fire = outAccept && outValid[0] && !flush;
  // Bypassed ops are consumed straight from the input and never written.
  assign q_deq    = (deq_fire && !byp_sel) ? deq_num : '0;
  assign byp_skip = (deq_fire && byp_sel) ? EW'(deq_num) : '0;
  assign enq_wr   = enq_fire ? (enq_num - byp_skip) : '0;

  // Pointer and occupancy update; flush wins over any same-cycle enqueue or dequeue.
  always_comb begin
    head_d  = head_q;
    tail_d  = tail_q;
    count_d = count_q;
    if (flush) begin
      head_d  = '0;
      tail_d  = '0;
      count_d = '0;
    end else begin
      head_d  = head_q + PW'(q_deq);
      tail_d  = tail_q + PW'(enq_wr);
      count_d = count_q + CW'(enq_wr) - CW'(q_deq);
    end
  end

  // Pointer and count registers; reset empties the queue immediately.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      head_q  <= '0;
      tail_q  <= '0;
      count_q <= '0;
    end else begin
      head_q  <= head_d;
      tail_q  <= tail_d;
      count_q <= count_d;
    end
  end

  // Entry storage is never reset; compacted ops not taken by bypass land at tail onward, wrapping.
  always_ff @(posedge clk) begin
    if (enq_fire) begin
      for (int c = 0; c < DECODE_WIDTH; c++) begin
        if ((EW'(c) >= byp_skip) && (EW'(c) < enq_num)) begin
          mem_q[tail_q + PW'(c) - PW'(byp_skip)] <= comp[c];
        end
      end
    end
  end

endmodule

// File: tb/tb_mop_rename_queue.sv
// Bench for mop_rename_queue: directed vector table, async reset sequence, randomized run vs. queue model.
// Inputs change 1 ns after the rising edge; outputs are checked on the falling edge.
// Model tracks program-order contents as a plain queue of ops.
module tb_mop_rename_queue;
  import mop_rename_queue_pkg::*;

  logic             clk;
  logic             rst;
  logic             flush;
  logic [1:0]       inValid;
  MopEntry [1:0]    inOp;
  logic             inReady;
  logic [1:0]       outValid;
  MopEntry [1:0]    outOp;
  logic             outAccept;
  logic [3:0]       count;

  int n_pass  = 0;
  int n_total = 0;

  mop_rename_queue dut (
    .clk       (clk),
    .rst       (rst),
    .flush     (flush),
    .inValid   (inValid),
    .inOp      (inOp),
    .inReady   (inReady),
    .outValid  (outValid),
    .outOp     (outOp),
    .outAccept (outAccept),
    .count     (count)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_total++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %0h, expected %0h", name, act, exp);
  endtask

  function automatic MopEntry rand_op(input int id, input logic ser);
    MopEntry e;
    e.opInfo     = 16'($urandom);
    e.pc         = $urandom;
    e.bPred      = 2'($urandom);
    e.opId       = 8'(id);
    e.serialized = ser;
    return e;
  endfunction

  typedef struct {
    logic       fl;
    logic [1:0] iv;
    logic [1:0] ser;
    logic       acc;
    int         cnt;
    logic       rdy;
    logic [1:0] ov;
    logic [1:0] ovb;
    int         id0;
    int         id1;
  } vec_t;

  vec_t tbl [32];
  MopEntry mq [$];

  initial begin
    //            fl  iv     ser    acc cnt rdy ov     ovb    id0 id1
    tbl[0]  = '{1'b0, 2'b10, 2'b00, 1'b0, 0, 1'b1, 2'b00, 2'b01, -1, -1};
    tbl[1]  = '{1'b0, 2'b00, 2'b00, 1'b1, 1, 1'b1, 2'b01, 2'b01,  1, -1};
    tbl[2]  = '{1'b0, 2'b11, 2'b00, 1'b0, 0, 1'b1, 2'b00, 2'b11, -1, -1};
    tbl[3]  = '{1'b0, 2'b11, 2'b00, 1'b0, 2, 1'b1, 2'b11, 2'b11,  4,  5};
    tbl[4]  = '{1'b0, 2'b11, 2'b00, 1'b0, 4, 1'b1, 2'b11, 2'b11,  4,  5};
    tbl[5]  = '{1'b0, 2'b11, 2'b00, 1'b0, 6, 1'b1, 2'b11, 2'b11,  4,  5};
    tbl[6]  = '{1'b0, 2'b11, 2'b00, 1'b0, 8, 1'b0, 2'b11, 2'b11,  4,  5};
    tbl[7]  = '{1'b0, 2'b11, 2'b00, 1'b1, 8, 1'b0, 2'b11, 2'b11,  4,  5};
    tbl[8]  = '{1'b0, 2'b11, 2'b00, 1'b0, 6, 1'b1, 2'b11, 2'b11,  6,  7};
    tbl[9]  = '{1'b1, 2'b11, 2'b00, 1'b1, 8, 1'b0, 2'b11, 2'b11,  6,  7};
    tbl[10] = '{1'b0, 2'b11, 2'b10, 1'b0, 0, 1'b1, 2'b00, 2'b01, -1, -1};
    tbl[11] = '{1'b0, 2'b01, 2'b00, 1'b0, 2, 1'b1, 2'b01, 2'b01, 20, -1};
    tbl[12] = '{1'b0, 2'b00, 2'b00, 1'b1, 3, 1'b1, 2'b01, 2'b01, 20, -1};
    tbl[13] = '{1'b0, 2'b00, 2'b00, 1'b1, 2, 1'b1, 2'b01, 2'b01, 21, -1};
    tbl[14] = '{1'b0, 2'b00, 2'b00, 1'b1, 1, 1'b1, 2'b01, 2'b01, 22, -1};
    tbl[15] = '{1'b0, 2'b00, 2'b00, 1'b0, 0, 1'b1, 2'b00, 2'b00, -1, -1};
    tbl[16] = '{1'b0, 2'b11, 2'b00, 1'b0, 0, 1'b1, 2'b00, 2'b11, -1, -1};
    tbl[17] = '{1'b0, 2'b11, 2'b00, 1'b0, 2, 1'b1, 2'b11, 2'b11, 32, 33};
    tbl[18] = '{1'b0, 2'b01, 2'b00, 1'b0, 4, 1'b1, 2'b11, 2'b11, 32, 33};
    tbl[19] = '{1'b1, 2'b11, 2'b00, 1'b1, 5, 1'b1, 2'b11, 2'b11, 32, 33};
    tbl[20] = '{1'b0, 2'b00, 2'b00, 1'b0, 0, 1'b1, 2'b00, 2'b00, -1, -1};
    tbl[21] = '{1'b0, 2'b11, 2'b00, 1'b0, 0, 1'b1, 2'b00, 2'b11, -1, -1};
    tbl[22] = '{1'b0, 2'b11, 2'b00, 1'b0, 2, 1'b1, 2'b11, 2'b11, 42, 43};
    tbl[23] = '{1'b0, 2'b11, 2'b00, 1'b0, 4, 1'b1, 2'b11, 2'b11, 42, 43};
    tbl[24] = '{1'b0, 2'b01, 2'b00, 1'b0, 6, 1'b1, 2'b11, 2'b11, 42, 43};
    tbl[25] = '{1'b0, 2'b00, 2'b00, 1'b1, 7, 1'b0, 2'b11, 2'b11, 42, 43};
    tbl[26] = '{1'b0, 2'b00, 2'b00, 1'b1, 5, 1'b1, 2'b11, 2'b11, 44, 45};
    tbl[27] = '{1'b0, 2'b00, 2'b00, 1'b1, 3, 1'b1, 2'b11, 2'b11, 46, 47};
    tbl[28] = '{1'b0, 2'b00, 2'b00, 1'b1, 1, 1'b1, 2'b01, 2'b01, 48, -1};
    tbl[29] = '{1'b0, 2'b11, 2'b00, 1'b0, 0, 1'b1, 2'b00, 2'b11, -1, -1};
    tbl[30] = '{1'b0, 2'b00, 2'b00, 1'b1, 2, 1'b1, 2'b11, 2'b11, 58, 59};
    tbl[31] = '{1'b0, 2'b00, 2'b00, 1'b0, 0, 1'b1, 2'b00, 2'b00, -1, -1};

    rst = 1'b1; flush = 1'b0; inValid = '0; inOp = '0; outAccept = 1'b0;
    #2;
    chk("reset_count", 64'(count), 64'd0);
    chk("reset_inReady", 64'(inReady), 64'd1);
    chk("reset_outValid", 64'(outValid), 64'd0);
    @(posedge clk); #1;
    rst = 1'b0;

    // Directed table
    for (int r = 0; r < 32; r++) begin
      logic [1:0] exp_ov;
      flush     = tbl[r].fl;
      inValid   = tbl[r].iv;
      outAccept = tbl[r].acc;
      for (int l = 0; l < 2; l++) inOp[l] = rand_op(r * 2 + l, tbl[r].ser[l]);
`ifdef RSD_MOP_QUEUE_BYPASS_EN
      exp_ov = tbl[r].ovb;
`else
      exp_ov = tbl[r].ov;
`endif
      #4;
      chk($sformatf("row%0d_count", r), 64'(count), 64'(tbl[r].cnt));
      chk($sformatf("row%0d_inReady", r), 64'(inReady), 64'(tbl[r].rdy));
      chk($sformatf("row%0d_outValid", r), 64'(outValid), 64'(exp_ov));
      if (tbl[r].cnt != 0 && exp_ov[0])
        chk($sformatf("row%0d_lane0_id", r), 64'(outOp[0].opId), 64'(tbl[r].id0));
      if (tbl[r].cnt != 0 && exp_ov[1])
        chk($sformatf("row%0d_lane1_id", r), 64'(outOp[1].opId), 64'(tbl[r].id1));
      @(posedge clk); #1;
    end

    // Async reset in the middle of a stream at occupancy 3
    flush = 1'b0; outAccept = 1'b0;
    inValid = 2'b11; inOp[0] = rand_op(100, 1'b0); inOp[1] = rand_op(101, 1'b0);
    @(posedge clk); #1;
    inValid = 2'b01; inOp[0] = rand_op(102, 1'b0);
    @(posedge clk); #1;
    inValid = 2'b00;
    #1;
    chk("pre_reset_count", 64'(count), 64'd3);
    rst = 1'b1;
    #1;
    chk("async_rst_outValid", 64'(outValid), 64'd0);
    chk("async_rst_inReady", 64'(inReady), 64'd1);
    chk("async_rst_count", 64'(count), 64'd0);
    #1;
    rst = 1'b0;
`ifdef RSD_MOP_QUEUE_BYPASS_EN
    inValid = 2'b10; inOp[1] = rand_op(103, 1'b0);
    #1;
    chk("bypass_outValid", 64'(outValid), 64'd1);
    chk("bypass_lane0_id", 64'(outOp[0].opId), 64'd103);
    outAccept = 1'b1;
    @(posedge clk); #1;
    inValid = 2'b00; outAccept = 1'b0;
    #1;
    chk("bypass_consumed_count", 64'(count), 64'd0);
`endif
    @(posedge clk); #1;

    // Randomized run against the program-order model
    mq.delete();
    for (int cyc = 0; cyc < 3000; cyc++) begin
      MopEntry cq [$];
      MopEntry cand [$];
      logic    byp;
      logic    exp_rdy;
      int      k;
      int      n;
      flush     = ($urandom_range(31) == 0);
      inValid   = 2'($urandom);
      outAccept = ($urandom_range(2) != 0);
      for (int l = 0; l < 2; l++) inOp[l] = rand_op(int'($urandom_range(255)), $urandom_range(3) == 0);
      #4;
      cq.delete();
      for (int l = 0; l < 2; l++) if (inValid[l]) cq.push_back(inOp[l]);
      exp_rdy = ((8 - mq.size()) >= 2);
`ifdef RSD_MOP_QUEUE_BYPASS_EN
      byp = (mq.size() == 0) && !flush;
`else
      byp = 1'b0;
`endif
      cand = byp ? cq : mq;
      k = (cand.size() < 2) ? cand.size() : 2;
      if (k == 0) n = 0;
      else if (cand[0].serialized) n = 1;
      else begin
        n = k;
        for (int j = 1; j < k; j++) if (cand[j].serialized && n == k) n = j;
      end
      chk($sformatf("rnd%0d_count", cyc), 64'(count), 64'(mq.size()));
      chk($sformatf("rnd%0d_inReady", cyc), 64'(inReady), 64'(exp_rdy));
      chk($sformatf("rnd%0d_outValid", cyc), 64'(outValid), 64'((1 << n) - 1));
      for (int l = 0; l < n; l++)
        chk($sformatf("rnd%0d_outOp%0d", cyc, l), 64'(outOp[l]), 64'(cand[l]));
      @(posedge clk);
      if (flush) mq.delete();
      else begin
        int taken;
        taken = (outAccept && n > 0) ? n : 0;
        if (!byp) for (int j = 0; j < taken; j++) void'(mq.pop_front());
        if (exp_rdy && cq.size() > 0)
          for (int j = (byp ? taken : 0); j < cq.size(); j++) mq.push_back(cq[j]);
      end
      #1;
    end

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
